vme_cmd_arbiter: RTL and testbench
==================================

# vme_cmd_arbiter

Synthesizable controller that shares the single VME command/data register path (address and R/W command word, write data in, read data out, start strobe) between NREQ internal requesters. It arbitrates round-robin and issues one transaction at a time to the VME register engine. It holds the command stable until the engine signals completion or a timeout expires, then returns read data and a one-cycle acknowledge to the winning requester. It sits between the TMB-internal masters (sequencers, self-test) and the VME command engine that the simulation file handler drives in test benches.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 255, cycles to wait in WAIT for completion before an error ack (1..255)

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- req  in  NREQ  per-requester request level; held until its ack
- req_wr  in  NREQ  1 = write, 0 = read; sampled with req at grant
- req_adr  in  NREQ*23  packed VME address bits [23:1], requester i at [23*i+:23]
- req_wdata  in  NREQ*32  packed write data, requester i at [32*i+:32]
- ack  out  NREQ  one-hot, one-cycle completion pulse
- err  out  1  valid with ack; 1 = timeout
- rdata  out  32  read data, valid with ack
- eng_ready  in  1  engine can accept a command
- start  out  1  one-cycle command strobe to the engine
- vme_cmd_reg  out  32  command word: [23:1] address, [24] write, [25] read, all other bits 0
- vme_dat_reg_in  out  32  write data to the engine (0 for reads)
- vme_dat_wr  in  1  engine completion strobe; result valid on vme_dat_reg_out
- vme_dat_reg_out  in  32  engine read-back data

## Operation
- States: IDLE, WAIT, DONE.
- Reset values: state=IDLE, rr pointer=0, start=0, vme_cmd_reg=0, vme_dat_reg_in=0, ack=0, err=0, rdata=0, timeout counter=0.
- IDLE:
  - If eng_ready=1 and req≠0, grant the first set req bit searching upward from the pointer, wrapping modulo NREQ.
  - On grant, load vme_cmd_reg and vme_dat_reg_in from the winner: [24]=req_wr, [25]=~req_wr.
  - Set start=1 for exactly one cycle, clear the counter, and go to WAIT.
  - If eng_ready=0, no grant is made and outputs stay 0.
- WAIT:
  - vme_cmd_reg and vme_dat_reg_in are held constant.
  - Counter increments each cycle.
  - vme_dat_wr=1: latch vme_dat_reg_out into rdata (reads; writes latch 0), err=0, go to DONE.
  - Counter reaches TIMEOUT with vme_dat_wr=0: rdata=0, err=1, go to DONE.
  - vme_dat_wr and timeout in the same cycle: completion wins, err=0.
- DONE:
  - ack[winner]=1 for this one cycle.
  - vme_cmd_reg and vme_dat_reg_in are cleared to 0.
  - Pointer = winner+1 mod NREQ.
  - Next state is IDLE unconditionally. DONE provides the turnaround so a held req is not regranted in its own ack cycle.
- vme_dat_wr outside WAIT is ignored.
- A requester dropping req mid-transaction does not abort it; the ack is still issued.
- Changes to req_adr, req_wdata or req_wr after grant are ignored.
- reset asserted at any point forces the reset values immediately. An in-flight transaction is abandoned with no ack.

## Timing
- Grant latency: req visible in IDLE at edge n → start=1 and command valid during cycle n+1.
- Completion: vme_dat_wr sampled at edge m → ack, rdata and err valid during cycle m+1.
- Back-to-back: minimum 3 cycles from one start to the next (WAIT ≥1, DONE 1, IDLE 1).
- Timeout: the error ack appears TIMEOUT+1 cycles after start.
- Counter width: 8 bits, saturating; the counter is never compared beyond TIMEOUT.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package vme_arb_pkg holds:
  - state enum: IDLE, WAIT, DONE
  - command bit constants: CMD_ADR_LSB=1, CMD_ADR_MSB=23, CMD_WR_BIT=24, CMD_RD_BIT=25
  - timeout counter width
- Sub-module rr_arbiter holds the round-robin search: NREQ parameter, inputs req and pointer, outputs one-hot grant and index. It is purely combinational and instantiated once.
- The FSM, counter and registers live in vme_cmd_arbiter.

## Test plan
- Single read: req[0]=1, req_wr=0, adr=0x000034. Engine returns vme_dat_wr 5 cycles after start with data 0x0000ABCD → vme_cmd_reg=0x02000068, ack[0] one cycle, rdata=0x0000ABCD, err=0.
- Single write: req[2], adr=0x000010, wdata=0x1234 → vme_cmd_reg=0x01000020, vme_dat_reg_in=0x00001234, ack[2] with rdata=0.
- Fairness: all four req held continuously and the engine answers in 1 cycle → grant order 0,1,2,3,0,1, with starts exactly 3 cycles apart.
- Timeout: TIMEOUT=8, engine never answers → ack with err=1 and rdata=0 exactly 9 cycles after start. Next IDLE grants the following requester.
- Collision and gating:
  - vme_dat_wr on the same cycle the counter hits TIMEOUT → err=0.
  - eng_ready=0 with req pending → start stays 0 until eng_ready=1.
- Reset mid-WAIT: assert reset with a command in flight → all outputs 0 immediately, no ack. After release, req[1] is granted first with pointer 0.

Source files
------------

// File: rtl/vme_arb_pkg.sv
// Shared definitions for the VME command arbiter.
//   arb_state_t : controller states (IDLE, WAIT, DONE)
//   CMD_*       : bit positions inside the VME command word
//   ADR_W       : width of the VME address field ([23:1])
//   CNT_W       : width of the saturating completion-timeout counter
package vme_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } arb_state_t;

  localparam int unsigned CMD_ADR_LSB = 1;
  localparam int unsigned CMD_ADR_MSB = 23;
  localparam int unsigned CMD_WR_BIT  = 24;
  localparam int unsigned CMD_RD_BIT  = 25;
  localparam int unsigned ADR_W       = CMD_ADR_MSB - CMD_ADR_LSB + 1;

  localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search.
//   req     : request vector
//   pointer : index of the highest-priority requester this round
//   grant   : one-hot winner (all zero when req is zero)
//   index   : binary index of the winner (0 when req is zero)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index
);

  logic          found;
  logic [IW-1:0] pos;

  // Scan upward from the pointer, wrapping modulo NREQ; first set bit wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = IW'((32'(pointer) + k) % NREQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

endmodule

// File: rtl/vme_cmd_arbiter.sv
// Shares the single VME command/data register path between NREQ requesters.
// Round-robin grant, one transaction in flight, completion or timeout,
// then a one-cycle ack with read data / error flag to the winner.
//   clk, reset          : clock, asynchronous active-high reset
//   req, req_wr         : per-requester request level and write flag
//   req_adr, req_wdata  : packed per-requester address [23:1] and write data
//   ack, err, rdata     : one-hot completion pulse, timeout flag, read data
//   eng_ready, start    : engine ready, one-cycle command strobe
//   vme_cmd_reg         : command word ([23:1] adr, [24] wr, [25] rd)
//   vme_dat_reg_in      : write data to engine (0 for reads)
//   vme_dat_wr          : engine completion strobe
//   vme_dat_reg_out     : engine read-back data
module vme_cmd_arbiter
  import vme_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*ADR_W-1:0] req_adr,
  input  logic [NREQ*32-1:0]    req_wdata,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [31:0]           rdata,
  input  logic                  eng_ready,
  output logic                  start,
  output logic [31:0]           vme_cmd_reg,
  output logic [31:0]           vme_dat_reg_in,
  input  logic                  vme_dat_wr,
  input  logic [31:0]           vme_dat_reg_out
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    winner;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    gidx;
  int unsigned      sel;
  logic [31:0]      grant_cmd;
  logic [31:0]      grant_wdata;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req     (req),
    .pointer (ptr),
    .grant   (grant),
    .index   (gidx)
  );

  // Command word and write data of the current round-robin candidate.
  always_comb begin
    sel         = 32'(gidx);
    grant_cmd   = '0;
    grant_cmd[CMD_ADR_MSB:CMD_ADR_LSB] = req_adr[sel*ADR_W +: ADR_W];
    grant_cmd[CMD_WR_BIT] = req_wr[gidx];
    grant_cmd[CMD_RD_BIT] = ~req_wr[gidx];
    grant_wdata = req_wr[gidx] ? req_wdata[sel*32 +: 32] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      winner         <= '0;
      cnt            <= '0;
      start          <= 1'b0;
      vme_cmd_reg    <= '0;
      vme_dat_reg_in <= '0;
      ack            <= '0;
      err            <= 1'b0;
      rdata          <= '0;
    end else begin
      start <= 1'b0;
      ack   <= '0;
      case (state)
        IDLE: begin
          if (eng_ready && (|grant)) begin
            winner         <= gidx;
            vme_cmd_reg    <= grant_cmd;
            vme_dat_reg_in <= grant_wdata;
            start          <= 1'b1;
            cnt            <= '0;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          // Completion takes priority over a timeout in the same cycle.
          if (vme_dat_wr || (cnt == CNT_W'(TIMEOUT))) begin
            rdata          <= (vme_dat_wr && vme_cmd_reg[CMD_RD_BIT]) ? vme_dat_reg_out : '0;
            err            <= ~vme_dat_wr;
            ack[winner]    <= 1'b1;
            vme_cmd_reg    <= '0;
            vme_dat_reg_in <= '0;
            state          <= DONE;
          end
        end
        DONE: begin
          // Turnaround cycle: a held req is not regranted while its ack is high.
          ptr   <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
          err   <= 1'b0;
          rdata <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
module tb_vme_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req, req_wr;
  logic [NREQ*23-1:0]   req_adr;
  logic [NREQ*32-1:0]   req_wdata;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic [31:0]          rdata;
  logic                 eng_ready, start;
  logic [31:0]          vme_cmd_reg, vme_dat_reg_in;
  logic                 vme_dat_wr;
  logic [31:0]          vme_dat_reg_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_ptr = 0;

  logic        m_wr  [NREQ];
  logic [22:0] m_adr [NREQ];
  logic [31:0] m_wd  [NREQ];

  // observations from run_txn
  bit gs, gh, ga;
  int sc, ac;
  logic [31:0] scmd, sdin, ard;
  logic [NREQ-1:0] aack;
  logic aerr;

  vme_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_adr(req_adr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata),
    .eng_ready(eng_ready), .start(start), .vme_cmd_reg(vme_cmd_reg),
    .vme_dat_reg_in(vme_dat_reg_in), .vme_dat_wr(vme_dat_wr),
    .vme_dat_reg_out(vme_dat_reg_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int exp_winner(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] exp_cmd(input logic [22:0] a, input logic w);
    return ({9'b0, a} << 1) | (w ? 32'h0100_0000 : 32'h0200_0000);
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [22:0] a, input logic [31:0] d);
    req_wr[i] = wr;
    req_adr[i*23 +: 23] = a;
    req_wdata[i*32 +: 32] = d;
    m_wr[i] = wr; m_adr[i] = a; m_wd[i] = d;
  endtask

  // Engine stand-in: waits for start, raises vme_dat_wr in the cycle that is
  // sampled at the lat-th edge after start (lat=0: never answers).
  task automatic run_txn(input int lat, input logic [31:0] data, input bit drop, input bit scramble);
    gs = 0; ga = 0; gh = 1; sc = 0; ac = 0; scmd = 0; sdin = 0; aack = 0; aerr = 0; ard = 0;
    for (int k = 0; k < 50 && !gs; k++) begin
      @(posedge clk); #1;
      if (start) begin gs = 1; sc = cyc; scmd = vme_cmd_reg; sdin = vme_dat_reg_in; end
    end
    if (!gs) return;
    if (scramble) begin
      req = '0;
      req_wr = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_adr[i*23 +: 23] = 23'($urandom);
        req_wdata[i*32 +: 32] = $urandom;
      end
    end
    for (int k = 1; k <= 300 && !ga; k++) begin
      if (k == lat) begin vme_dat_wr = 1'b1; vme_dat_reg_out = data; end
      @(posedge clk); #1;
      vme_dat_wr = 1'b0;
      vme_dat_reg_out = $urandom;
      if (ack != '0) begin
        ga = 1; ac = cyc; aack = ack; aerr = err; ard = rdata;
        if (drop) for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
      end else if (vme_cmd_reg !== scmd || vme_dat_reg_in !== sdin) begin
        gh = 0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; req = '0; req_wr = '0; req_adr = '0; req_wdata = '0;
    eng_ready = 1'b1; vme_dat_wr = 1'b0; vme_dat_reg_out = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
    repeat (3) @(posedge clk); #1;
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack got %h want 0", ack); end
    checks++; if (start !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_start_err got %b%b want 00", start, err); end
    checks++; if (vme_cmd_reg !== '0 || vme_dat_reg_in !== '0) begin errors++; $display("FAIL reset_cmd got %h/%h want 0/0", vme_cmd_reg, vme_dat_reg_in); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_fairness;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int prev;
    logic [NREQ-1:0] e;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 23'(16'h100 + i), $urandom);
    req = 4'hF;
    prev = 0;
    for (int n = 0; n < 6; n++) begin
      run_txn(1, $urandom, 1'b0, 1'b0);
      e = '0; e[order[n]] = 1'b1;
      checks++; if (!ga || aack !== e) begin errors++; $display("FAIL fair_order[%0d] got %b want %b", n, aack, e); end
      checks++; if (exp_winner(4'hF, model_ptr) != order[n]) begin errors++; $display("FAIL fair_model[%0d] got %0d want %0d", n, exp_winner(4'hF, model_ptr), order[n]); end
      if (n > 0) begin
        checks++; if (sc - prev != 3) begin errors++; $display("FAIL fair_gap[%0d] got %0d want 3", n, sc - prev); end
      end
      prev = sc;
      model_ptr = (order[n] + 1) % NREQ;
    end
    req = '0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_single_read;
    set_req(0, 1'b0, 23'h000034, $urandom);
    req = 4'b0001;
    run_txn(5, 32'h0000ABCD, 1'b1, 1'b0);
    checks++; if (!gs || scmd !== 32'h0200_0068) begin errors++; $display("FAIL rd_cmd got %h want 02000068", scmd); end
    checks++; if (sdin !== '0) begin errors++; $display("FAIL rd_din got %h want 0", sdin); end
    checks++; if (!ga || aack !== 4'b0001 || ac - sc != 5) begin errors++; $display("FAIL rd_ack got %b lat %0d want 0001 lat 5", aack, ac - sc); end
    checks++; if (ard !== 32'h0000ABCD || aerr !== 1'b0) begin errors++; $display("FAIL rd_data got %h err %b want 0000abcd err 0", ard, aerr); end
    checks++; if (!gh) begin errors++; $display("FAIL rd_hold got changed want held"); end
    @(posedge clk); #1;
    checks++; if (ack !== '0) begin errors++; $display("FAIL rd_ack_width got %b want 0", ack); end
    model_ptr = 1;
  endtask

  task automatic test_single_write;
    set_req(2, 1'b1, 23'h000010, 32'h0000_1234);
    req = 4'b0100;
    run_txn(3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    checks++; if (!gs || scmd !== 32'h0100_0020) begin errors++; $display("FAIL wr_cmd got %h want 01000020", scmd); end
    checks++; if (sdin !== 32'h0000_1234) begin errors++; $display("FAIL wr_din got %h want 00001234", sdin); end
    checks++; if (!ga || aack !== 4'b0100 || ard !== '0 || aerr !== 1'b0) begin errors++; $display("FAIL wr_ack got %b rdata %h err %b want 0100 0 0", aack, ard, aerr); end
    model_ptr = 3;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 23'(i * 7 + 3), '0);
    req = 4'hF;
    run_txn(0, '0, 1'b1, 1'b0);
    checks++; if (!ga || aack !== 4'b1000) begin errors++; $display("FAIL to_ack got %b want 1000", aack); end
    checks++; if (aerr !== 1'b1 || ard !== '0) begin errors++; $display("FAIL to_err got err %b rdata %h want 1 0", aerr, ard); end
    checks++; if (ac - sc != TO + 1) begin errors++; $display("FAIL to_lat got %0d want %0d", ac - sc, TO + 1); end
    model_ptr = 0;
    run_txn(2, 32'h5555_AAAA, 1'b1, 1'b0);
    checks++; if (!ga || aack !== 4'b0001 || aerr !== 1'b0 || ard !== 32'h5555_AAAA) begin errors++; $display("FAIL to_next got %b err %b rdata %h want 0001 0 5555aaaa", aack, aerr, ard); end
    model_ptr = 1;
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_collision;
    set_req(1, 1'b0, 23'h7FFFFF, '0);
    req = 4'b0010;
    run_txn(TO + 1, 32'hC011_1DE0, 1'b1, 1'b0);
    checks++; if (!ga || aerr !== 1'b0 || ard !== 32'hC011_1DE0 || ac - sc != TO + 1) begin errors++; $display("FAIL coll got err %b rdata %h lat %0d want 0 c0111de0 %0d", aerr, ard, ac - sc, TO + 1); end
    checks++; if (scmd !== 32'h02FF_FFFE) begin errors++; $display("FAIL coll_cmd got %h want 02fffffe", scmd); end
    model_ptr = 2;
    set_req(2, 1'b0, 23'h1, '0);
    req = 4'b0100;
    run_txn(TO, 32'h1111_2222, 1'b1, 1'b0);
    checks++; if (!ga || aerr !== 1'b0 || ard !== 32'h1111_2222 || ac - sc != TO) begin errors++; $display("FAIL coll_edge got err %b rdata %h lat %0d want 0 11112222 %0d", aerr, ard, ac - sc, TO); end
    model_ptr = 3;
    @(posedge clk); #1;
  endtask

  task automatic test_gating;
    int rel;
    eng_ready = 1'b0;
    set_req(0, 1'b1, 23'h2A, 32'hFEED_0001);
    req = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      vme_dat_wr = n[0];
      @(posedge clk); #1;
      checks++; if (start !== 1'b0 || ack !== '0) begin errors++; $display("FAIL gate[%0d] got start %b ack %b want 0 0", n, start, ack); end
    end
    vme_dat_wr = 1'b0;
    eng_ready = 1'b1;
    rel = cyc;
    run_txn(2, '0, 1'b1, 1'b0);
    checks++; if (!gs || sc - rel != 1) begin errors++; $display("FAIL gate_release got delay %0d want 1", sc - rel); end
    checks++; if (!ga || aack !== 4'b0001 || sdin !== 32'hFEED_0001) begin errors++; $display("FAIL gate_txn got %b din %h want 0001 feed0001", aack, sdin); end
    model_ptr = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [NREQ-1:0] m, e;
    int w, lat;
    logic [31:0] d, er;
    int elat;
    logic eerr;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), 23'($urandom), $urandom);
      m = 4'($urandom_range(1, 15));
      lat = $urandom_range(0, 12);
      d = $urandom;
      w = exp_winner(m, model_ptr);
      e = '0; e[w] = 1'b1;
      if (lat >= 1 && lat <= TO + 1) begin elat = lat; eerr = 1'b0; er = m_wr[w] ? 32'h0 : d; end
      else begin elat = TO + 1; eerr = 1'b1; er = '0; end
      req = m;
      run_txn(lat, d, 1'b1, n[0]);
      checks++; if (!gs || scmd !== exp_cmd(m_adr[w], m_wr[w]) || sdin !== (m_wr[w] ? m_wd[w] : 32'h0)) begin errors++; $display("FAIL rnd_cmd[%0d] got %h/%h want %h/%h", n, scmd, sdin, exp_cmd(m_adr[w], m_wr[w]), m_wr[w] ? m_wd[w] : 32'h0); end
      checks++; if (!ga || aack !== e || ac - sc != elat) begin errors++; $display("FAIL rnd_ack[%0d] got %b lat %0d want %b lat %0d", n, aack, ac - sc, e, elat); end
      checks++; if (aerr !== eerr || ard !== er) begin errors++; $display("FAIL rnd_res[%0d] got err %b rdata %h want %b %h", n, aerr, ard, eerr, er); end
      checks++; if (!gh) begin errors++; $display("FAIL rnd_hold[%0d] got changed want held", n); end
      model_ptr = (w + 1) % NREQ;
      req = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait;
    bit seen;
    set_req(2, 1'b0, 23'h22, '0);
    req = 4'b0100;
    run_txn(1, '0, 1'b1, 1'b0);
    set_req(3, 1'b0, 23'h33, '0);
    req = 4'b1000;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin @(posedge clk); #1; seen = start; end
    checks++; if (!seen) begin errors++; $display("FAIL rst_start got none want start"); end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (start !== 1'b0 || ack !== '0 || vme_cmd_reg !== '0 || vme_dat_reg_in !== '0 || err !== 1'b0 || rdata !== '0) begin errors++; $display("FAIL rst_async got cmd %h ack %b want all 0", vme_cmd_reg, ack); end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 23'(16'h40 + i), '0);
    req = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      vme_dat_wr = 1'b1;
      @(posedge clk); #1;
      checks++; if (ack !== '0 || start !== 1'b0) begin errors++; $display("FAIL rst_hold[%0d] got ack %b start %b want 0 0", k, ack, start); end
    end
    vme_dat_wr = 1'b0;
    reset = 1'b0;
    model_ptr = 0;
    run_txn(1, 32'h0BAD_F00D, 1'b1, 1'b0);
    checks++; if (!ga || aack !== 4'b0010 || scmd !== exp_cmd(m_adr[1], 1'b0)) begin errors++; $display("FAIL rst_regrant got %b cmd %h want 0010 %h", aack, scmd, exp_cmd(m_adr[1], 1'b0)); end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_fairness;
    test_single_read;
    test_single_write;
    test_timeout;
    test_collision;
    test_gating;
    test_random;
    test_reset_mid_wait;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
